// File: rtl/seq_comparator_n.sv
// rtl/seq_comparator_n.sv - digit-serial L/E/G magnitude comparator, MSB/LSB-first, signed/unsigned
module seq_comparator_n #(
    parameter int DIGIT_W    = 1,
    parameter int NUM_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               lsb_first,
    input  logic               is_signed,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic [2:0]         out,
    output logic               done,
    output logic               busy
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

    state_t           state, state_nxt;
    rel_t             rel, digit_rel;
    logic [CNT_W-1:0] count;
    logic             lsb_q, signed_q, done_q;
    logic             accept, msd, last_beat, digit_lt;

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = done_q;
    // start wins over data in the same cycle, so that beat is dropped
    assign accept    = in_ready && in_valid && !start;
    assign last_beat = (count == LAST);
    assign msd       = lsb_q ? last_beat : (count == '0);

    always_comb begin
        digit_lt  = 1'b0;
        digit_rel = REL_EQ;
        if (a_digit != b_digit) begin
            if (signed_q && msd)
                digit_lt = ($signed(a_digit) < $signed(b_digit));
            else
                digit_lt = (a_digit < b_digit);
            digit_rel = digit_lt ? REL_LT : REL_GT;
        end
    end

    always_comb begin
        state_nxt = state;
        out       = 3'b000;
        if (start) begin
            state_nxt = RUN;
        end else if (state == RUN && accept && last_beat) begin
            state_nxt = DONE;
        end
        if (state == DONE) begin
            case (rel)
                REL_LT:  out = 3'b100;
                REL_GT:  out = 3'b001;
                default: out = 3'b010;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rel      <= REL_EQ;
            lsb_q    <= 1'b0;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= accept && last_beat;
            if (start) begin
                count    <= '0;
                rel      <= REL_EQ;
                lsb_q    <= lsb_first;
                signed_q <= is_signed;
            end else if (accept) begin
                count <= count + CNT_W'(1);
                // MSB-first: first difference sticks; LSB-first: latest difference wins
                if (lsb_q ? (digit_rel != REL_EQ) : (rel == REL_EQ))
                    rel <= digit_rel;
            end
        end
    end

endmodule

// File: tb/tb_seq_comparator_n.sv
// tb/tb_seq_comparator_n.sv - directed checks of seq_comparator_n in 4x2 and 1x8 configurations
module tb_seq_comparator_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       s4 = 0, l4 = 0, g4 = 0, v4 = 0, r4, dn4, bz4;
    logic [3:0] a4 = 0, b4 = 0;
    logic [2:0] o4;

    logic       s1 = 0, l1 = 0, g1 = 0, v1 = 0, r1, dn1, bz1;
    logic [0:0] a1 = 0, b1 = 0;
    logic [2:0] o1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_comparator_n #(.DIGIT_W(4), .NUM_DIGITS(2)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .lsb_first(l4), .is_signed(g4),
        .in_valid(v4), .in_ready(r4), .a_digit(a4), .b_digit(b4),
        .out(o4), .done(dn4), .busy(bz4)
    );

    seq_comparator_n #(.DIGIT_W(1), .NUM_DIGITS(8)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .lsb_first(l1), .is_signed(g1),
        .in_valid(v1), .in_ready(r1), .a_digit(a1), .b_digit(b1),
        .out(o1), .done(dn1), .busy(bz1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 2-digit comparison on dut4; mode pins are flipped after start to prove they are latched
    task automatic run4(input string tag, input logic lsb, input logic sgn,
                        input logic [7:0] a, input logic [7:0] b,
                        input int gap, input logic [2:0] exp);
        int d;
        s4 = 1; l4 = lsb; g4 = sgn; v4 = (gap > 0);
        step();
        s4 = 0; l4 = ~lsb; g4 = ~sgn;
        chk({tag, "_busy_run"}, {7'd0, bz4}, 8'd1);
        chk({tag, "_out_run"}, {5'd0, o4}, 8'd0);
        for (int i = 0; i < 2; i++) begin
            d  = lsb ? i : 1 - i;
            a4 = a[d*4 +: 4];
            b4 = b[d*4 +: 4];
            v4 = 1;
            step();
            if (gap > 0 && i == 0) begin
                v4 = 0;
                repeat (gap) step();
                chk({tag, "_gap_busy"}, {7'd0, bz4}, 8'd1);
                chk({tag, "_gap_done"}, {7'd0, dn4}, 8'd0);
            end
        end
        chk({tag, "_out"}, {5'd0, o4}, {5'd0, exp});
        chk({tag, "_done"}, {7'd0, dn4}, 8'd1);
        chk({tag, "_busy_done"}, {7'd0, bz4}, 8'd0);
        v4 = (gap > 0);
        step();
        chk({tag, "_done_clr"}, {7'd0, dn4}, 8'd0);
        chk({tag, "_out_hold"}, {5'd0, o4}, {5'd0, exp});
        chk({tag, "_ready_done"}, {7'd0, r4}, 8'd0);
        v4 = 0;
    endtask

    task automatic run1(input string tag, input logic sgn,
                        input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp);
        s1 = 1; l1 = 0; g1 = sgn;
        step();
        s1 = 0;
        for (int i = 0; i < 8; i++) begin
            a1 = a[7-i];
            b1 = b[7-i];
            v1 = 1;
            step();
            if (i < 7) chk({tag, "_no_early_done"}, {7'd0, dn1}, 8'd0);
        end
        v1 = 0;
        chk({tag, "_out"}, {5'd0, o1}, {5'd0, exp});
        chk({tag, "_done"}, {7'd0, dn1}, 8'd1);
        step();
        chk({tag, "_done_clr"}, {7'd0, dn1}, 8'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_out4", {5'd0, o4}, 8'd0);
        chk("rst_busy4", {7'd0, bz4}, 8'd0);
        chk("rst_done4", {7'd0, dn4}, 8'd0);
        chk("rst_ready4", {7'd0, r4}, 8'd0);
        chk("rst_out1", {5'd0, o1}, 8'd0);
        rst = 0;
        step();
        chk("idle_ready4", {7'd0, r4}, 8'd0);

        run4("u_msb_gt",   0, 0, 8'h3C, 8'h35, 0, 3'b001);
        run4("u_msb_eq",   0, 0, 8'hA5, 8'hA5, 0, 3'b010);
        run4("s_msb_lt",   0, 1, 8'h80, 8'h7F, 0, 3'b100);
        run4("u_msb_80",   0, 0, 8'h80, 8'h7F, 0, 3'b001);
        run4("u_lsb_lt",   1, 0, 8'h1F, 8'h2E, 0, 3'b100);
        run4("u_lsb_gt",   1, 0, 8'h2F, 8'h1F, 0, 3'b001);
        run4("s_lsb_lt",   1, 1, 8'hF0, 8'h10, 0, 3'b100);
        run4("gap_msb_gt", 0, 0, 8'h3C, 8'h35, 3, 3'b001);
        run4("gap_lsb_lt", 1, 0, 8'h1F, 8'h2E, 3, 3'b100);

        // abort: (F,0) accepted, (9,0) dropped on restart cycle, then (1,3),(2,4) => A<B
        s4 = 1; l4 = 0; g4 = 0;
        step();
        s4 = 0; a4 = 4'hF; b4 = 4'h0; v4 = 1;
        step();
        s4 = 1; a4 = 4'h9; b4 = 4'h0;
        step();
        chk("abort_no_done", {7'd0, dn4}, 8'd0);
        chk("abort_busy", {7'd0, bz4}, 8'd1);
        s4 = 0; a4 = 4'h1; b4 = 4'h3;
        step();
        chk("abort_mid_done", {7'd0, dn4}, 8'd0);
        a4 = 4'h2; b4 = 4'h4;
        step();
        v4 = 0;
        chk("abort_out", {5'd0, o4}, 8'h04);
        chk("abort_done", {7'd0, dn4}, 8'd1);
        step();
        chk("abort_single_done", {7'd0, dn4}, 8'd0);

        // reset mid-RUN
        s4 = 1;
        step();
        s4 = 0; a4 = 4'h5; b4 = 4'h1; v4 = 1;
        step();
        rst = 1;
        step();
        rst = 0; v4 = 0;
        chk("mrst_out", {5'd0, o4}, 8'd0);
        chk("mrst_busy", {7'd0, bz4}, 8'd0);
        chk("mrst_done", {7'd0, dn4}, 8'd0);
        chk("mrst_ready", {7'd0, r4}, 8'd0);
        step();
        chk("mrst_idle_busy", {7'd0, bz4}, 8'd0);
        run4("post_rst_eq", 0, 0, 8'h5A, 8'h5A, 0, 3'b010);

        run1("b1_s_lt", 1, 8'h80, 8'h00, 3'b100);
        run1("b1_u_eq", 0, 8'h01, 8'h01, 3'b010);
        run1("b1_u_gt", 0, 8'h80, 8'h00, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
